intpol2_iq_out_buffer: RTL and testbench
========================================

Name: intpol2_iq_out_buffer

Overview:
- Receive end of the interpolator output stream. Captures I_interp/Q_interp samples qualified by the core's write-enable into an 8-deep I/Q FIFO.
- Returns almost-full back-pressure to the core's Afull input.
- Lets the host or a downstream consumer drain the samples as packed 32-bit words, one read pulse per sample.
- Sits directly after the IQ interpolator core, in place of an external output FIFO.

Parameters:
- DATAPATH_WIDTH, 12, width of each I and Q sample (two's complement).
- ADDR_WIDTH, 3, FIFO address bits; depth DEPTH = 2**ADDR_WIDTH = 8.
- AF_DIFF, 2, number of free locations at or below which Afull_o asserts.

Ports:
- clk  in  1  single clock, rising edge.
- rst_a  in  1  asynchronous reset, active low.
- Write_Enable_i  in  1  sample-valid strobe from interpolator core.
- I_interp_i  in  DATAPATH_WIDTH  I sample.
- Q_interp_i  in  DATAPATH_WIDTH  Q sample.
- Afull_o  out  1  almost-full back-pressure to core.
- rd_i  in  1  read request, one sample per high cycle.
- data_o  out  32  packed output word.
- valid_o  out  1  one-cycle strobe: data_o updated this cycle.
- Empty_o  out  1  FIFO empty.
- Full_o  out  1  FIFO full.
- count_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a sample was dropped because the FIFO was full.
- clr_ovf_i  in  1  synchronous clear of overflow_o.

Behaviour:
- Reset (rst_a=0, async):
  - Read/write pointers and count go to 0.
  - Empty_o=1, Full_o=0, Afull_o=0.
  - data_o=0, valid_o=0, overflow_o=0.
  - Stored contents are don't-care.
  - Reset mid-stream discards all buffered samples. No valid_o pulse may follow reset release unless rd_i is issued after a new write.
- Storage:
  - Entry = {Q,I}, 2*DATAPATH_WIDTH bits.
  - Write pointer and read pointer are ADDR_WIDTH bits and wrap naturally from 7 to 0.
- Write:
  - When Write_Enable_i=1 and (Full_o=0 or a read is accepted in the same cycle), store {Q_interp_i,I_interp_i} at wr_ptr and increment wr_ptr.
  - When Write_Enable_i=1, Full_o=1 and no read is accepted, drop the sample, leave pointers unchanged, and set overflow_o on the next edge.
- Read:
  - When rd_i=1 and Empty_o=0, data_o is registered on that edge.
  - data_o = {sign-extend Q to 16 bits, sign-extend I to 16 bits}.
  - valid_o=1 for exactly that cycle; rd_ptr increments.
  - Latency: 1 clock from rd_i to valid_o.
  - rd_i while Empty_o=1 is ignored: valid_o=0, data_o holds, pointers unchanged.
  - No fall-through: a sample written in cycle N is readable from cycle N+1 at the earliest.
- Simultaneous read and write:
  - Non-empty and non-full: both occur, count unchanged.
  - Full: the read frees a slot and the write is accepted; count stays DEPTH, no overflow.
  - Empty: the write is accepted and the read is ignored; count becomes 1.
- Flags, all registered and updated on the same edge as count:
  - Empty_o = (count==0).
  - Full_o = (count==DEPTH).
  - Afull_o = (count >= DEPTH-AF_DIFF), i.e. count>=6 with the default parameters.
- Overflow:
  - clr_ovf_i=1 clears overflow_o on the next edge.
  - If a drop and clr_ovf_i occur in the same cycle, set wins and overflow_o stays 1.
- Arithmetic: count is ADDR_WIDTH+1 bits and never exceeds DEPTH or drops below 0.

Test Plan:
- Reset check: assert rst_a=0 mid-run with count=5 -> all outputs return to reset values immediately; after release, rd_i gives valid_o=0.
- Basic path: write I=12'h7FF, Q=12'h800, then pulse rd_i -> one cycle later data_o=32'hF800_07FF, valid_o=1 for one cycle, Empty_o=1 afterwards.
- Fill and back-pressure: 8 back-to-back writes of I=k, Q=k+16 (k=0..7):
  - Afull_o rises after the 6th write and Full_o after the 8th; count_o=8.
  - A 9th write sets overflow_o=1 and is dropped.
  - 8 reads return k=0..7 in order.
- Wrap-around: run 20 continuous write+read cycles with occupancy held at 3 -> output order is preserved across pointer wrap, count_o stays 3, flags stay stable.
- Simultaneous events:
  - At Full, rd_i and Write_Enable_i together -> count stays 8, overflow_o stays 0, and the new sample is read 8th in order.
  - At Empty, both together -> valid_o=0, count=1.
- Overflow clear: with overflow_o=1, pulse clr_ovf_i -> overflow_o=0. Pulse clr_ovf_i together with a dropped write -> overflow_o remains 1.

Source files
------------

// File: rtl/intpol2_iq_out_buffer_if.sv
// Bus between the IQ interpolator core / host and the output buffer.
// master = the side that produces samples and issues reads,
// slave  = the buffer itself.
interface intpol2_iq_out_buffer_if #(
    parameter int DATAPATH_WIDTH = 12,
    parameter int ADDR_WIDTH     = 3
);
    logic                      Write_Enable_i;
    logic [DATAPATH_WIDTH-1:0] I_interp_i;
    logic [DATAPATH_WIDTH-1:0] Q_interp_i;
    logic                      Afull_o;
    logic                      rd_i;
    logic [31:0]               data_o;
    logic                      valid_o;
    logic                      Empty_o;
    logic                      Full_o;
    logic [ADDR_WIDTH:0]       count_o;
    logic                      overflow_o;
    logic                      clr_ovf_i;

    modport master (
        output Write_Enable_i, I_interp_i, Q_interp_i, rd_i, clr_ovf_i,
        input  Afull_o, data_o, valid_o, Empty_o, Full_o, count_o, overflow_o
    );

    modport slave (
        input  Write_Enable_i, I_interp_i, Q_interp_i, rd_i, clr_ovf_i,
        output Afull_o, data_o, valid_o, Empty_o, Full_o, count_o, overflow_o
    );
endinterface

// File: rtl/intpol2_iq_out_buffer.sv
// Output buffer for the IQ interpolator: an 8-deep {Q,I} FIFO with
// registered flags, almost-full back-pressure to the core, a sticky
// overflow indicator and a 1-cycle-latency packed 32-bit read port.
module intpol2_iq_out_buffer #(
    parameter int DATAPATH_WIDTH = 12,
    parameter int ADDR_WIDTH     = 3,
    parameter int AF_DIFF        = 2
) (
    input logic clk,
    input logic rst_a,
    intpol2_iq_out_buffer_if.slave bus
);
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int CNT_W   = ADDR_WIDTH + 1;
    localparam int ENTRY_W = 2 * DATAPATH_WIDTH;
    localparam int EXT_W   = 16 - DATAPATH_WIDTH;

    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wrPtr;
    logic [ADDR_WIDTH-1:0] r_rdPtr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_afull;
    logic [31:0]           r_data;
    logic                  r_valid;
    logic                  r_overflow;

    logic                      w_rdAccept;
    logic                      w_wrAccept;
    logic                      w_drop;
    logic [CNT_W-1:0]          w_countNext;
    logic [ENTRY_W-1:0]        w_rdEntry;
    logic [DATAPATH_WIDTH-1:0] w_rdI;
    logic [DATAPATH_WIDTH-1:0] w_rdQ;

    // A read needs stored data; a write at full is only taken if a read
    // frees a slot on the same edge, otherwise the sample is dropped.
    always_comb begin
        w_rdAccept = bus.rd_i && !r_empty;
        w_wrAccept = bus.Write_Enable_i && (!r_full || w_rdAccept);
        w_drop     = bus.Write_Enable_i && r_full && !w_rdAccept;
        w_rdEntry  = r_mem[r_rdPtr];
        w_rdI      = w_rdEntry[DATAPATH_WIDTH-1:0];
        w_rdQ      = w_rdEntry[ENTRY_W-1:DATAPATH_WIDTH];
    end

    // Occupancy for the next cycle; simultaneous read+write cancels out.
    always_comb begin
        w_countNext = r_count;
        if (w_wrAccept && !w_rdAccept) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_wrAccept && w_rdAccept) begin
            w_countNext = r_count - CNT_W'(1);
        end
    end

    // Sample storage; contents need no reset because pointers guard them.
    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_mem[r_wrPtr] <= {bus.Q_interp_i, bus.I_interp_i};
        end
    end

    // Pointers, occupancy and flags, all updated together from the next count.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + ADDR_WIDTH'(1);
            end
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + ADDR_WIDTH'(1);
            end
            r_count <= w_countNext;
            r_empty <= (w_countNext == '0);
            r_full  <= (w_countNext == CNT_W'(DEPTH));
            r_afull <= (w_countNext >= CNT_W'(DEPTH - AF_DIFF));
        end
    end

    // Read port: register the sign-extended packed word and strobe valid.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rdAccept;
            if (w_rdAccept) begin
                r_data <= {{EXT_W{w_rdQ[DATAPATH_WIDTH-1]}}, w_rdQ,
                           {EXT_W{w_rdI[DATAPATH_WIDTH-1]}}, w_rdI};
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf_i) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.Afull_o    = r_afull;
    assign bus.Full_o     = r_full;
    assign bus.Empty_o    = r_empty;
    assign bus.count_o    = r_count;
    assign bus.data_o     = r_data;
    assign bus.valid_o    = r_valid;
    assign bus.overflow_o = r_overflow;
endmodule

// File: tb/tb_intpol2_iq_out_buffer.sv
// Self-checking bench for intpol2_iq_out_buffer: a table of directed
// vectors plus hand-written wrap-around, full-simultaneous and reset sequences.
module tb_intpol2_iq_out_buffer;
    logic clk;
    logic rst_a;

    intpol2_iq_out_buffer_if #(.DATAPATH_WIDTH(12), .ADDR_WIDTH(3)) bus ();

    intpol2_iq_out_buffer #(
        .DATAPATH_WIDTH(12),
        .ADDR_WIDTH    (3),
        .AF_DIFF       (2)
    ) dut (
        .clk  (clk),
        .rst_a(rst_a),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [11:0] iS;
        logic [11:0] qS;
        logic        rd;
        logic        clr;
        logic        expValid;
        logic [31:0] expData;
        logic [3:0]  expCount;
        logic        expEmpty;
        logic        expFull;
        logic        expAfull;
        logic        expOvf;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] model[$];
    int          testsRun    = 0;
    int          testsFailed = 0;

    // Free-running 100 MHz-style clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic we, logic [11:0] iS, logic [11:0] qS,
                                logic rd, logic clr, logic v, logic [31:0] d,
                                logic [3:0] c, logic e, logic f, logic a,
                                logic o);
        vec_t t;
        t.we = we; t.iS = iS; t.qS = qS; t.rd = rd; t.clr = clr;
        t.expValid = v; t.expData = d; t.expCount = c; t.expEmpty = e;
        t.expFull = f; t.expAfull = a; t.expOvf = o;
        return t;
    endfunction

    function automatic logic [31:0] pack(logic [11:0] iS, logic [11:0] qS);
        return {{4{qS[11]}}, qS, {4{iS[11]}}, iS};
    endfunction

    // Drive one cycle of inputs on the falling edge, then wait until just
    // after the next rising edge so outputs are sampled away from the edge.
    task automatic applyStimulus(logic we, logic [11:0] iS, logic [11:0] qS,
                                 logic rd, logic clr);
        @(negedge clk);
        bus.Write_Enable_i = we;
        bus.I_interp_i     = iS;
        bus.Q_interp_i     = qS;
        bus.rd_i           = rd;
        bus.clr_ovf_i      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkFlags(string tag, logic [3:0] c, logic e, logic f,
                              logic a, logic o);
        checkOutput({tag, ".count"}, 32'(bus.count_o), 32'(c));
        checkOutput({tag, ".empty"}, 32'(bus.Empty_o), 32'(e));
        checkOutput({tag, ".full"},  32'(bus.Full_o),  32'(f));
        checkOutput({tag, ".afull"}, 32'(bus.Afull_o), 32'(a));
        checkOutput({tag, ".ovf"},   32'(bus.overflow_o), 32'(o));
    endtask

    initial begin
        logic [11:0] iS;
        logic [11:0] qS;
        logic [31:0] expD;

        rst_a              = 1'b0;
        bus.Write_Enable_i = 1'b0;
        bus.I_interp_i     = '0;
        bus.Q_interp_i     = '0;
        bus.rd_i           = 1'b0;
        bus.clr_ovf_i      = 1'b0;

        // ---- Reset values while held in reset ----
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.valid", 32'(bus.valid_o), 32'd0);
        checkOutput("rst.data", bus.data_o, 32'd0);
        checkFlags("rst", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_a = 1'b1;

        // ---- Directed vector table ----
        vecs.push_back(mk(0, 12'h000, 12'h000, 0, 0, 0, 32'h0, 4'd0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 12'h7FF, 12'h800, 0, 0, 0, 32'h0, 4'd1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 1, 32'hF800_07FF, 4'd0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 12'h000, 0, 0, 0, 32'hF800_07FF, 4'd0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 0, 32'hF800_07FF, 4'd0, 1, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(1, 12'(k), 12'(k + 16), 0, 0, 0, 32'hF800_07FF,
                              4'(k + 1), 0, (k == 7), (k + 1 >= 6), 0));
        end
        vecs.push_back(mk(1, 12'h123, 12'h456, 0, 0, 0, 32'hF800_07FF, 4'd8, 0, 1, 1, 1));
        vecs.push_back(mk(0, 12'h000, 12'h000, 0, 1, 0, 32'hF800_07FF, 4'd8, 0, 1, 1, 0));
        vecs.push_back(mk(1, 12'h321, 12'h654, 0, 1, 0, 32'hF800_07FF, 4'd8, 0, 1, 1, 1));
        vecs.push_back(mk(0, 12'h000, 12'h000, 0, 0, 0, 32'hF800_07FF, 4'd8, 0, 1, 1, 1));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 1,
                              {16'(k + 16), 16'(k)}, 4'(7 - k),
                              (k == 7), 0, (7 - k >= 6), 1));
        end
        vecs.push_back(mk(0, 12'h000, 12'h000, 0, 1, 0, 32'h0017_0007, 4'd0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 12'h001, 12'hFFF, 1, 0, 0, 32'h0017_0007, 4'd1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 12'h000, 1, 0, 1, 32'hFFFF_0001, 4'd0, 1, 0, 0, 0));

        foreach (vecs[n]) begin
            string tag;
            tag = $sformatf("vec%0d", n);
            applyStimulus(vecs[n].we, vecs[n].iS, vecs[n].qS, vecs[n].rd, vecs[n].clr);
            checkOutput({tag, ".valid"}, 32'(bus.valid_o), 32'(vecs[n].expValid));
            checkOutput({tag, ".data"}, bus.data_o, vecs[n].expData);
            checkFlags(tag, vecs[n].expCount, vecs[n].expEmpty, vecs[n].expFull,
                       vecs[n].expAfull, vecs[n].expOvf);
        end

        // ---- Wrap-around with occupancy held at 3 ----
        for (int k = 0; k < 3; k++) begin
            iS = 12'(12'h100 + k);
            qS = 12'(12'hF00 - k);
            applyStimulus(1, iS, qS, 0, 0);
            model.push_back(pack(iS, qS));
        end
        checkFlags("wrap.pre", 4'd3, 0, 0, 0, 0);
        for (int k = 3; k < 23; k++) begin
            iS = 12'(12'h100 + k);
            qS = 12'(12'hF00 - k);
            expD = model.pop_front();
            model.push_back(pack(iS, qS));
            applyStimulus(1, iS, qS, 1, 0);
            checkOutput($sformatf("wrap%0d.valid", k), 32'(bus.valid_o), 32'd1);
            checkOutput($sformatf("wrap%0d.data", k), bus.data_o, expD);
            checkFlags($sformatf("wrap%0d", k), 4'd3, 0, 0, 0, 0);
        end
        for (int k = 0; k < 3; k++) begin
            expD = model.pop_front();
            applyStimulus(0, 12'h000, 12'h000, 1, 0);
            checkOutput($sformatf("wrapDrain%0d.data", k), bus.data_o, expD);
        end
        checkFlags("wrap.post", 4'd0, 1, 0, 0, 0);

        // ---- Simultaneous read and write at full ----
        for (int k = 0; k < 8; k++) begin
            iS = 12'(12'h800 + k * 3);
            qS = 12'(12'h055 + k);
            applyStimulus(1, iS, qS, 0, 0);
            model.push_back(pack(iS, qS));
        end
        checkFlags("full.pre", 4'd8, 0, 1, 1, 0);
        expD = model.pop_front();
        model.push_back(pack(12'hABC, 12'h5A5));
        applyStimulus(1, 12'hABC, 12'h5A5, 1, 0);
        checkOutput("fullRW.valid", 32'(bus.valid_o), 32'd1);
        checkOutput("fullRW.data", bus.data_o, expD);
        checkFlags("fullRW", 4'd8, 0, 1, 1, 0);
        for (int k = 0; k < 8; k++) begin
            expD = model.pop_front();
            applyStimulus(0, 12'h000, 12'h000, 1, 0);
            checkOutput($sformatf("fullDrain%0d.data", k), bus.data_o, expD);
        end
        checkOutput("fullDrain.lastIsNew", bus.data_o, 32'h05A5_FABC);
        checkFlags("fullDrain", 4'd0, 1, 0, 0, 0);

        // ---- Asynchronous reset mid-stream with count=5 ----
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 12'(k + 1), 12'(k + 1), 0, 0);
        end
        applyStimulus(0, 12'h000, 12'h000, 1, 0);
        checkOutput("midrst.preValid", 32'(bus.valid_o), 32'd1);
        applyStimulus(1, 12'h00F, 12'h00F, 0, 1);
        bus.Write_Enable_i = 1'b0;
        bus.clr_ovf_i      = 1'b0;
        checkFlags("midrst.pre", 4'd5, 0, 0, 0, 0);
        #2;
        rst_a = 1'b0;
        #1;
        checkOutput("midrst.valid", 32'(bus.valid_o), 32'd0);
        checkOutput("midrst.data", bus.data_o, 32'd0);
        checkFlags("midrst", 4'd0, 1, 0, 0, 0);
        @(negedge clk);
        rst_a = 1'b1;
        applyStimulus(0, 12'h000, 12'h000, 1, 0);
        checkOutput("postrst.valid", 32'(bus.valid_o), 32'd0);
        checkOutput("postrst.data", bus.data_o, 32'd0);
        checkFlags("postrst", 4'd0, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
